// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and response codes used by the link and its endpoints.
package axi_lite_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite link bundle: five channels with master and slave views.
interface axi_lite_if;
  import axi_lite_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  logic  bvalid;
  logic  bready;
  resp_t bresp;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  logic  rvalid;
  logic  rready;
  data_t rdata;
  resp_t rresp;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register file: NUM_REGS byte-strobed 32-bit registers,
// SLVERR for accesses outside the register window.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 8,
  parameter addr_t       BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_lite_if.slave              s_axi_lite,
  output logic [NUM_REGS*32-1:0] reg_q,
  output logic [NUM_REGS-1:0]    reg_wr
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [32:0] SPAN  = 33'(NUM_REGS * 4);

  // 33-bit offset so addresses below BASE_ADDR wrap to a huge value and fail the compare.
  function automatic logic addr_in_range(input addr_t addr);
    logic [32:0] offset;
    offset = {1'b0, addr} - {1'b0, BASE_ADDR};
    return offset < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input addr_t addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  function automatic data_t strobe_merge(input data_t old_word, input data_t new_word,
                                         input strb_t strb);
    data_t merged;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = strb[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
    end
    return merged;
  endfunction

  logic                aw_held_q, aw_held_d;
  addr_t               awaddr_q,  awaddr_d;
  logic                w_held_q,  w_held_d;
  data_t               wdata_q,   wdata_d;
  strb_t               wstrb_q,   wstrb_d;
  logic                bvalid_q,  bvalid_d;
  resp_t               bresp_q,   bresp_d;
  logic                rvalid_q,  rvalid_d;
  data_t               rdata_q,   rdata_d;
  resp_t               rresp_q,   rresp_d;
  logic [NUM_REGS-1:0] reg_wr_q,  reg_wr_d;
  data_t               regs_q [NUM_REGS];
  data_t               regs_d [NUM_REGS];

  logic                aw_hs_s, w_hs_s, ar_hs_s, commit_s, wr_ok_s, rd_ok_s;
  logic [IDX_W-1:0]    wr_idx_s, rd_idx_s;
  data_t               rd_word_s;

  assign s_axi_lite.awready = !aw_held_q && !bvalid_q && !rst;
  assign s_axi_lite.wready  = !w_held_q  && !bvalid_q && !rst;
  assign s_axi_lite.arready = !rvalid_q && !rst;
  assign s_axi_lite.bvalid  = bvalid_q;
  assign s_axi_lite.bresp   = bresp_q;
  assign s_axi_lite.rvalid  = rvalid_q;
  assign s_axi_lite.rdata   = rdata_q;
  assign s_axi_lite.rresp   = rresp_q;
  assign reg_wr             = reg_wr_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[32*g +: 32] = regs_q[g];
  end

  assign aw_hs_s  = s_axi_lite.awvalid && s_axi_lite.awready;
  assign w_hs_s   = s_axi_lite.wvalid  && s_axi_lite.wready;
  assign ar_hs_s  = s_axi_lite.arvalid && s_axi_lite.arready;
  assign commit_s = aw_held_q && w_held_q;
  assign wr_ok_s  = addr_in_range(awaddr_q);
  assign wr_idx_s = addr_index(awaddr_q);
  assign rd_ok_s  = addr_in_range(s_axi_lite.araddr);
  assign rd_idx_s = addr_index(s_axi_lite.araddr);

  // Write path: collect AW and W independently, commit once both are held.
  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    reg_wr_d  = '0;
    if (commit_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_ok_s) begin
        bresp_d = RESP_OKAY;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_idx_s == IDX_W'(i)) begin
            regs_d[i]   = strobe_merge(regs_q[i], wdata_q, wstrb_q);
            reg_wr_d[i] = 1'b1;
          end else begin
            regs_d[i]   = regs_q[i];
          end
        end
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end else begin
      if (aw_hs_s) begin
        aw_held_d = 1'b1;
        awaddr_d  = s_axi_lite.awaddr;
      end else begin
        aw_held_d = aw_held_q;
      end
      if (w_hs_s) begin
        w_held_d = 1'b1;
        wdata_d  = s_axi_lite.wdata;
        wstrb_d  = s_axi_lite.wstrb;
      end else begin
        w_held_d = w_held_q;
      end
      if (bvalid_q && s_axi_lite.bready) begin
        bvalid_d = 1'b0;
      end else begin
        bvalid_d = bvalid_q;
      end
    end
  end

  // Read path: sample the pre-commit register value on the AR handshake.
  always_comb begin
    rd_word_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_word_s = (rd_idx_s == IDX_W'(i)) ? regs_q[i] : rd_word_s;
    end
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      if (rd_ok_s) begin
        rdata_d = rd_word_s;
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end else if (rvalid_q && s_axi_lite.rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // State registers; reset drops any half-accepted write and pending responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      reg_wr_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      reg_wr_q  <= reg_wr_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: vector table, corner sequences, random traffic vs model.
module tb_axi_lite_slave_regs;
  import axi_lite_pkg::*;

  localparam int    NR   = 8;
  localparam addr_t BASE = 32'h4000_0100;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0]    reg_wr;
  int               total = 0;
  int               bad = 0;
  data_t            model [NR];

  typedef struct {
    addr_t         waddr;
    data_t         wdata;
    strb_t         wstrb;
    resp_t         bresp;
    logic [NR-1:0] wr;
    addr_t         raddr;
    data_t         rdata;
    resp_t         rresp;
  } vec_t;
  vec_t vecs [8];

  axi_lite_if bus ();

  axi_lite_slave_regs #(.NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axi_lite (bus),
    .reg_q      (reg_q),
    .reg_wr     (reg_wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_win(addr_t a);
    return (a >= BASE) && (a < BASE + 32'(NR * 4));
  endfunction

  function automatic int idx_of(addr_t a);
    return int'((a - BASE) / 32'd4);
  endfunction

  function automatic logic [NR-1:0] exp_wr(addr_t a);
    logic [NR-1:0] m;
    m = '0;
    if (in_win(a)) m[idx_of(a)] = 1'b1;
    return m;
  endfunction

  function automatic data_t exp_rd(addr_t a);
    if (in_win(a)) return model[idx_of(a)];
    return 32'h0;
  endfunction

  task automatic model_write(input addr_t a, input data_t d, input strb_t s);
    if (in_win(a)) begin
      for (int k = 0; k < 4; k++) begin
        if (s[k]) model[idx_of(a)][8*k +: 8] = d[8*k +: 8];
      end
    end
  endtask

  task automatic check_regq();
    for (int i = 0; i < NR; i++) check("reg_q", reg_q[32*i +: 32], model[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_in_reset", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check("resp_in_reset", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata, reg_wr},
          {2'b00, 2'b00, 2'b00, 32'h0, {NR{1'b0}}});
    rst = 1'b0;
    #1;
    check("ready_after_reset", {bus.awready, bus.wready, bus.arready}, 3'b111);
    @(negedge clk);
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
  endtask

  // Called at a negedge; valids follow their own delays, B accepted after b_dly stall cycles.
  task automatic axi_write(input addr_t a, input data_t d, input strb_t s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input resp_t e_resp, input logic [NR-1:0] e_wr);
    bit aw_done, w_done, hs_aw, hs_w;
    int c, n;
    aw_done = 1'b0; w_done = 1'b0; c = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    while (!(aw_done && w_done) && c < 40) begin
      bus.awvalid = !aw_done && (c >= aw_dly);
      bus.wvalid  = !w_done && (c >= w_dly);
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      @(negedge clk);
      aw_done |= hs_aw;
      w_done  |= hs_w;
      c++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("aw_w_accepted", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!bus.bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b_latency", n, 1);
    check("bresp", bus.bresp, e_resp);
    check("reg_wr_pulse", reg_wr, e_wr);
    for (int k = 0; k < b_dly; k++) begin
      @(negedge clk);
      check("b_stall", {bus.bvalid, bus.bresp, bus.awready, bus.wready, reg_wr},
            {1'b1, e_resp, 2'b00, {NR{1'b0}}});
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("b_clear", bus.bvalid, 1'b0);
  endtask

  task automatic axi_read(input addr_t a, input data_t e_d, input resp_t e_r, input int r_dly);
    int n;
    bus.araddr = a; bus.arvalid = 1'b1; n = 0;
    while (!bus.arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("r_valid", bus.rvalid, 1'b1);
    check("rdata", bus.rdata, e_d);
    check("rresp", bus.rresp, e_r);
    for (int k = 0; k < r_dly; k++) begin
      @(negedge clk);
      check("r_stall", {bus.rvalid, bus.rresp, bus.rdata, bus.arready}, {1'b1, e_r, e_d, 1'b0});
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("r_clear", bus.rvalid, 1'b0);
  endtask

  initial begin
    addr_t a;
    data_t d, old;
    strb_t s;

    rst = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    vecs[0] = '{BASE + 32'h08, 32'hDEADBEEF, 4'hF, RESP_OKAY,   8'h04, BASE + 32'h08, 32'hDEADBEEF, RESP_OKAY};
    vecs[1] = '{BASE + 32'h04, 32'hAAAAAAAA, 4'hF, RESP_OKAY,   8'h02, BASE + 32'h04, 32'hAAAAAAAA, RESP_OKAY};
    vecs[2] = '{BASE + 32'h04, 32'h11223344, 4'h5, RESP_OKAY,   8'h02, BASE + 32'h04, 32'hAA22AA44, RESP_OKAY};
    vecs[3] = '{BASE + 32'h20, 32'h12345678, 4'hF, RESP_SLVERR, 8'h00, BASE + 32'h20, 32'h0,        RESP_SLVERR};
    vecs[4] = '{BASE - 32'h04, 32'h87654321, 4'hF, RESP_SLVERR, 8'h00, BASE - 32'h04, 32'h0,        RESP_SLVERR};
    vecs[5] = '{BASE + 32'h1F, 32'hCAFEF00D, 4'h3, RESP_OKAY,   8'h80, BASE + 32'h1C, 32'h0000F00D, RESP_OKAY};
    vecs[6] = '{BASE + 32'h08, 32'hFFFFFFFF, 4'h0, RESP_OKAY,   8'h04, BASE + 32'h09, 32'hDEADBEEF, RESP_OKAY};
    vecs[7] = '{BASE + 32'h00, 32'h01020304, 4'hC, RESP_OKAY,   8'h01, BASE + 32'h03, 32'h01020000, RESP_OKAY};

    do_reset();
    for (int i = 0; i < NR; i++) axi_read(BASE + 32'(4 * i), 32'h0, RESP_OKAY, 0);

    for (int v = 0; v < 8; v++) begin
      axi_write(vecs[v].waddr, vecs[v].wdata, vecs[v].wstrb, 0, 0, 0, vecs[v].bresp, vecs[v].wr);
      model_write(vecs[v].waddr, vecs[v].wdata, vecs[v].wstrb);
      check_regq();
      axi_read(vecs[v].raddr, vecs[v].rdata, vecs[v].rresp, 0);
    end

    // W leads AW by 3 cycles, then B is stalled so new AW/W must be refused.
    axi_write(BASE + 32'h0C, 32'hAAAAAAAA, 4'hF, 0, 0, 0, RESP_OKAY, 8'h08);
    model_write(BASE + 32'h0C, 32'hAAAAAAAA, 4'hF);
    axi_write(BASE + 32'h0C, 32'h11223344, 4'b0101, 3, 0, 3, RESP_OKAY, 8'h08);
    model_write(BASE + 32'h0C, 32'h11223344, 4'b0101);
    check("partial_strobe", reg_q[32*3 +: 32], 32'hAA22AA44);
    axi_read(BASE + 32'h0C, 32'hAA22AA44, RESP_OKAY, 0);

    // Backpressure: write and read of register 2 both held for 5 cycles.
    old = model[2];
    bus.awaddr = BASE + 32'h08; bus.wdata = 32'h13572468; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.araddr = BASE + 32'h08; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_b", {bus.bvalid, bus.bresp}, {1'b1, RESP_OKAY});
      check("bp_r", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, RESP_OKAY, old});
      check("bp_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
      @(negedge clk);
    end
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0; bus.rready = 1'b0;
    check("bp_release", {bus.bvalid, bus.rvalid}, 2'b00);
    model_write(BASE + 32'h08, 32'h13572468, 4'hF);
    axi_read(BASE + 32'h08, 32'h13572468, RESP_OKAY, 0);

    // AR on the commit edge of a write to the same register sees the old value.
    axi_write(BASE + 32'h04, 32'h9, 4'hF, 0, 0, 0, RESP_OKAY, 8'h02);
    model_write(BASE + 32'h04, 32'h9, 4'hF);
    bus.awaddr = BASE + 32'h04; bus.wdata = 32'h5; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = BASE + 32'h04; bus.arvalid = 1'b1;
    check("coll_arready", bus.arready, 1'b1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("coll_rdata", {bus.rvalid, bus.rdata}, {1'b1, 32'h9});
    check("coll_b", {bus.bvalid, bus.bresp, reg_wr}, {1'b1, RESP_OKAY, 8'h02});
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0; bus.rready = 1'b0;
    model_write(BASE + 32'h04, 32'h5, 4'hF);
    axi_read(BASE + 32'h04, 32'h5, RESP_OKAY, 0);

    // Reset with only AW held: the half write must vanish.
    bus.awaddr = BASE + 32'h04; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    do_reset();
    bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("no_b_after_reset", {bus.bvalid, reg_wr}, {1'b0, {NR{1'b0}}});
      @(negedge clk);
    end
    axi_read(BASE + 32'h04, 32'h0, RESP_OKAY, 0);
    do_reset();

    for (int t = 0; t < 300; t++) begin
      a = BASE - 32'd8 + 32'($urandom_range(0, NR * 4 + 15));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  in_win(a) ? RESP_OKAY : RESP_SLVERR, exp_wr(a));
        model_write(a, d, s);
        check_regq();
      end else begin
        axi_read(a, exp_rd(a), in_win(a) ? RESP_OKAY : RESP_SLVERR, $urandom_range(0, 2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

AXI4-Lite slave register file; the responder end of the AXI4-Lite link that the team's master drives. Decodes 32-bit word addresses into `NUM_REGS` read/write 32-bit registers with byte-strobe writes, and answers out-of-range accesses with SLVERR. Register contents and per-register write pulses go to local control logic.

## Interface
- `NUM_REGS`, 8: number of 32-bit registers (2..256).
- `BASE_ADDR`, 32'h0000_0000: byte address of register 0; must be aligned to `NUM_REGS*4` rounded up to a power of two.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `s_axi_lite` axi_lite_if.slave: AXI4-Lite slave modport, all five channels.
  - Drives: awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp.
  - Samples: awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready.
  - Address and data use addr_t and data_t (32 bits each); wstrb is 4 bits; responses are RESP_OKAY and RESP_SLVERR.
- `reg_q` out NUM_REGS*32: flattened register contents; register i occupies bits [32*i+31:32*i].
- `reg_wr` out NUM_REGS: one-cycle pulse per register; asserted in the cycle after that register is written, aligned with bvalid rising.

## Operation
- **Decode**
  - Offset = addr − BASE_ADDR; index = offset[2 +: clog2(NUM_REGS)].
  - Address bits [1:0] are ignored.
  - An access is in range iff BASE_ADDR ≤ addr < BASE_ADDR + NUM_REGS*4.
- **Write path**
  - AW and W are accepted independently, in either order or in the same cycle.
  - Two hold flags, aw_held and w_held, latch awaddr and wdata/wstrb respectively.
  - awready = !aw_held && !bvalid && !rst. wready = !w_held && !bvalid && !rst.
  - In any cycle where aw_held && w_held, the clock edge performs the commit:
    - If in range: register byte k takes wdata byte k only where wstrb[k]=1; bresp = RESP_OKAY; reg_wr[index] pulses.
    - If out of range: no register changes; bresp = RESP_SLVERR; no reg_wr pulse.
    - Both hold flags clear and bvalid sets.
  - bvalid, bresp hold until bready; bvalid clears on the bvalid && bready edge.
  - No new AW or W is accepted while bvalid=1, so at most one write is outstanding.
- **Read path**
  - arready = !rvalid && !rst.
  - On the AR handshake edge:
    - rvalid sets.
    - If in range: rdata = register[index], rresp = RESP_OKAY.
    - If out of range: rdata = 0, rresp = RESP_SLVERR.
  - rvalid, rdata, rresp hold stable until rready; rvalid clears on the handshake edge.
- **Independence:** read and write paths are independent and may complete in the same cycle.

## Timing
- **Reset**
  - All registers 0, reg_q = 0, reg_wr = 0.
  - bvalid = 0, rvalid = 0, bresp = 0, rresp = 0, rdata = 0, hold flags cleared.
  - All ready outputs are 0 while rst = 1 and 1 in the first cycle after release.
- **Reset mid-operation:** reset asserted with a half-accepted write or a pending response drops it silently; no commit and no response after release.
- **Write latency**
  - AW and W handshake on the same edge T: commit and bvalid=1 at edge T+1.
  - Handshakes on separate edges: commit on the edge after the later of the two.
- **Read latency:** AR handshake at edge T gives rvalid=1, with data, after T.
- **Back-to-back**
  - With bready held high, the next AW/W is accepted the cycle after B completes: one write per 3 cycles.
  - With rready held high, arready returns the cycle after R completes: one read per 2 cycles.
- **Same-register collision:** AR handshake on the same edge as a write commit to the same register returns the pre-write value.
- **Strobe edge case:** wstrb = 0 with an in-range address commits with no data change, returns OKAY and still pulses reg_wr.

## Test plan
- **Reset:** apply reset, then read every register → rdata = 0, rresp = OKAY, ready signals low during reset.
- **Full write then read:** AW/W same cycle, addr BASE+0x8, data 0xDEADBEEF, wstrb 4'hF → bvalid one cycle later, bresp = OKAY, reg_wr[2] pulse. Read BASE+0x8 → 0xDEADBEEF.
- **Partial strobe:** W before AW by 3 cycles, data 0x11223344, wstrb 4'b0101, to a register holding 0xAAAAAAAA → register = 0xAA22AA44; awready stays low until the B handshake.
- **Out of range:** write to BASE+NUM_REGS*4 → bresp = SLVERR, no reg_q change, no reg_wr pulse. Read of the same address → rdata = 0, rresp = SLVERR.
- **Backpressure:** hold bready and rready low for 5 cycles → bvalid/bresp and rvalid/rdata/rresp stable throughout; no further AW/W/AR accepted.
- **Collision and reset:** AR to register 1 on the same edge as a write commit of 0x5 to register 1 (old value 0x9) → rdata = 0x9. Reset asserted with only AW held → no B response after release and register 1 still reads 0.
